// File: rtl/sc_regread_arbiter.sv
// sc_regread_arbiter: arbitrates the general-register read mux between the MIR field and the scratchpad port
// MIR has fixed priority; the scratchpad wins once MIR has taken STARVE_LIMIT grants in a row while it waited.
// Optional macro SC_REGARB_LOCK_EN adds SC_REGARB_MIRLock_In, which holds MIR priority across microcode sequences.
module sc_regread_arbiter #(
    parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
    parameter int DATAWIDTH_MIR_DIRECTION        = 6,
    parameter int STARVE_LIMIT                   = 4
) (
    input  logic                                      SC_REGARB_CLOCK_50,
    input  logic                                      SC_REGARB_RESET_InHigh,
    input  logic                                      SC_REGARB_MIRReq_In,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0]        SC_REGARB_MIRAddr_InBus,
    input  logic                                      SC_REGARB_SPReq_In,
    input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_REGARB_SPAddr_InBus,
`ifdef SC_REGARB_LOCK_EN
    input  logic                                      SC_REGARB_MIRLock_In,
`endif
    output logic                                      SC_REGARB_MIRGrant_Out,
    output logic                                      SC_REGARB_SPGrant_Out,
    output logic                                      SC_REGARB_MuxSelect_Out,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]        SC_REGARB_MuxMIRSel_OutBus,
    output logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] SC_REGARB_MuxSPSel_OutBus,
    output logic                                      SC_REGARB_DataValid_Out,
    output logic                                      SC_REGARB_AddrErr_Out
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GNT_MIR = 2'd1;
    localparam logic [1:0] GNT_SP  = 2'd2;
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    logic [1:0]                                state_q, state_d;
    logic [3:0]                                starve_q, starve_d;
    logic                                      sel_q, sel_d;
    logic                                      err_q, err_d;
    logic [DATAWIDTH_MIR_DIRECTION-1:0]        mir_sel_q, mir_sel_d;
    logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] sp_sel_q, sp_sel_d;
    logic                                      mir_win, sp_win, suppress;

`ifdef SC_REGARB_LOCK_EN
    logic lock_q, lock_d;
    // lock flag: armed by a MIR grant under lock, dropped as soon as the lock input falls
    always_comb lock_d = SC_REGARB_MIRLock_In & (lock_q | mir_win);
    // lock flag register
    always_ff @(posedge SC_REGARB_CLOCK_50 or posedge SC_REGARB_RESET_InHigh)
        if (SC_REGARB_RESET_InHigh) lock_q <= 1'b0;
        else lock_q <= lock_d;
    assign suppress = lock_q & SC_REGARB_MIRLock_In;
`else
    assign suppress = 1'b0;
`endif

    // arbitration decision and next-state values, evaluated from the live requests every edge
    always_comb begin
        sp_win    = SC_REGARB_SPReq_In & (~SC_REGARB_MIRReq_In | (starve_q == LIMIT && !suppress));
        mir_win   = SC_REGARB_MIRReq_In & ~sp_win;
        state_d   = mir_win ? GNT_MIR : sp_win ? GNT_SP : IDLE;
        starve_d  = (!SC_REGARB_SPReq_In || sp_win) ? 4'd0 :
                    (mir_win && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
        sel_d     = mir_win ? 1'b1 : sp_win ? 1'b0 : sel_q;
        mir_sel_d = mir_win ? SC_REGARB_MIRAddr_InBus : mir_sel_q;
        sp_sel_d  = sp_win ? SC_REGARB_SPAddr_InBus : sp_sel_q;
        err_d     = mir_win ? |SC_REGARB_MIRAddr_InBus[DATAWIDTH_MIR_DIRECTION-1:4] :
                    sp_win  ? |SC_REGARB_SPAddr_InBus[DATAWIDTH_SCRATCHPAD_DIRECTION-1:4] : 1'b0;
    end

    // state, starve counter and registered mux controls
    always_ff @(posedge SC_REGARB_CLOCK_50 or posedge SC_REGARB_RESET_InHigh) begin
        if (SC_REGARB_RESET_InHigh) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            sel_q     <= 1'b0;
            err_q     <= 1'b0;
            mir_sel_q <= '0;
            sp_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            mir_sel_q <= mir_sel_d;
            sp_sel_q  <= sp_sel_d;
        end
    end

    assign SC_REGARB_MIRGrant_Out     = state_q == GNT_MIR;
    assign SC_REGARB_SPGrant_Out      = state_q == GNT_SP;
    assign SC_REGARB_DataValid_Out    = state_q != IDLE;
    assign SC_REGARB_MuxSelect_Out    = sel_q;
    assign SC_REGARB_MuxMIRSel_OutBus = mir_sel_q;
    assign SC_REGARB_MuxSPSel_OutBus  = sp_sel_q;
    assign SC_REGARB_AddrErr_Out      = err_q;
endmodule

// File: tb/tb_sc_regread_arbiter.sv
// tb_sc_regread_arbiter: vector table plus hand-written reset, starvation and lock sequences
module tb_sc_regread_arbiter;
    logic clk = 1'b0, rst = 1'b1, mreq = 1'b0, sreq = 1'b0;
    logic [5:0] maddr = '0;
    logic [4:0] saddr = '0;
`ifdef SC_REGARB_LOCK_EN
    logic lock = 1'b0;
`endif
    logic mg, sg, sel, dv, err;
    logic [5:0] ms;
    logic [4:0] ss;

    sc_regread_arbiter dut (
        .SC_REGARB_CLOCK_50(clk),
        .SC_REGARB_RESET_InHigh(rst),
        .SC_REGARB_MIRReq_In(mreq),
        .SC_REGARB_MIRAddr_InBus(maddr),
        .SC_REGARB_SPReq_In(sreq),
        .SC_REGARB_SPAddr_InBus(saddr),
`ifdef SC_REGARB_LOCK_EN
        .SC_REGARB_MIRLock_In(lock),
`endif
        .SC_REGARB_MIRGrant_Out(mg),
        .SC_REGARB_SPGrant_Out(sg),
        .SC_REGARB_MuxSelect_Out(sel),
        .SC_REGARB_MuxMIRSel_OutBus(ms),
        .SC_REGARB_MuxSPSel_OutBus(ss),
        .SC_REGARB_DataValid_Out(dv),
        .SC_REGARB_AddrErr_Out(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mg, sg, sel;
        logic [5:0] ms;
        logic [4:0] ss;
        logic dv, err;
    } out_t;

    typedef struct {
        logic m;
        logic [5:0] ma;
        logic s;
        logic [4:0] sa;
        out_t e;
    } vec_t;

    vec_t tbl[25];
    out_t sb[$];
    int errs = 0, checks = 0;

    function automatic vec_t mk(logic m, logic [5:0] ma, logic s, logic [4:0] sa, logic emg, logic esg,
                                logic esel, logic [5:0] ems, logic [4:0] ess, logic edv, logic eerr);
        vec_t v;
        v.m = m; v.ma = ma; v.s = s; v.sa = sa;
        v.e = '{emg, esg, esel, ems, ess, edv, eerr};
        return v;
    endfunction

    function automatic out_t grant_m(logic [5:0] ems, logic [4:0] ess, logic eerr);
        return '{1'b1, 1'b0, 1'b1, ems, ess, 1'b1, eerr};
    endfunction

    function automatic out_t grant_s(logic [5:0] ems, logic [4:0] ess, logic eerr);
        return '{1'b0, 1'b1, 1'b0, ems, ess, 1'b1, eerr};
    endfunction

    task automatic chk(string n, out_t exp);
        out_t a;
        a = '{mg, sg, sel, ms, ss, dv, err};
        checks++;
        if (a !== exp) begin
            errs++;
            $display("FAIL %s: got mg=%b sg=%b sel=%b ms=%0d ss=%0d dv=%b err=%b, expected mg=%b sg=%b sel=%b ms=%0d ss=%0d dv=%b err=%b",
                     n, a.mg, a.sg, a.sel, a.ms, a.ss, a.dv, a.err,
                     exp.mg, exp.sg, exp.sel, exp.ms, exp.ss, exp.dv, exp.err);
        end
    endtask

    initial begin
        //            m  ma  s  sa   mg sg sel ms  ss  dv err
        tbl[0]  = mk(1, 5,  0, 0,   1, 0, 1,  5,  0,  1, 0);
        tbl[1]  = mk(0, 0,  1, 12,  0, 1, 0,  5,  12, 1, 0);
        tbl[2]  = mk(0, 0,  1, 12,  0, 1, 0,  5,  12, 1, 0);
        tbl[3]  = mk(0, 0,  1, 12,  0, 1, 0,  5,  12, 1, 0);
        tbl[4]  = mk(0, 0,  0, 0,   0, 0, 0,  5,  12, 0, 0);
        tbl[5]  = mk(1, 20, 0, 0,   1, 0, 1,  20, 12, 1, 1);
        tbl[6]  = mk(1, 7,  1, 3,   1, 0, 1,  7,  12, 1, 0);
        tbl[7]  = mk(1, 8,  1, 3,   1, 0, 1,  8,  12, 1, 0);
        tbl[8]  = mk(1, 9,  1, 3,   1, 0, 1,  9,  12, 1, 0);
        tbl[9]  = mk(1, 10, 1, 3,   1, 0, 1,  10, 12, 1, 0);
        tbl[10] = mk(1, 10, 1, 3,   0, 1, 0,  10, 3,  1, 0);
        tbl[11] = mk(1, 11, 1, 3,   1, 0, 1,  11, 3,  1, 0);
        tbl[12] = mk(1, 12, 1, 3,   1, 0, 1,  12, 3,  1, 0);
        tbl[13] = mk(1, 13, 1, 3,   1, 0, 1,  13, 3,  1, 0);
        tbl[14] = mk(1, 14, 1, 17,  1, 0, 1,  14, 3,  1, 0);
        tbl[15] = mk(1, 15, 1, 17,  0, 1, 0,  14, 17, 1, 1);
        tbl[16] = mk(1, 48, 0, 0,   1, 0, 1,  48, 17, 1, 1);
        tbl[17] = mk(0, 0,  0, 0,   0, 0, 1,  48, 17, 0, 0);
        tbl[18] = mk(1, 1,  1, 2,   1, 0, 1,  1,  17, 1, 0);
        tbl[19] = mk(0, 0,  0, 0,   0, 0, 1,  1,  17, 0, 0);
        tbl[20] = mk(1, 2,  1, 4,   1, 0, 1,  2,  17, 1, 0);
        tbl[21] = mk(1, 3,  1, 4,   1, 0, 1,  3,  17, 1, 0);
        tbl[22] = mk(1, 4,  1, 4,   1, 0, 1,  4,  17, 1, 0);
        tbl[23] = mk(1, 5,  1, 4,   1, 0, 1,  5,  17, 1, 0);
        tbl[24] = mk(1, 6,  1, 4,   0, 1, 0,  5,  4,  1, 0);

        @(negedge clk);
        chk("reset_state", '0);
        for (int i = 0; i < 25; i++) begin
            mreq = tbl[i].m; maddr = tbl[i].ma; sreq = tbl[i].s; saddr = tbl[i].sa;
            sb.push_back(tbl[i].e);
            if (i == 0) rst = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d", i), sb.pop_front());
        end

        // reset asserted while the scratchpad owns the mux, cleared without a clock edge
        mreq = 1'b0; sreq = 1'b1; saddr = 5'd9;
        @(negedge clk);
        chk("sp_before_rst", grant_s(6'd5, 5'd9, 1'b0));
        #2 rst = 1'b1;
        #1 chk("async_rst", '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("sp_after_rst", grant_s(6'd0, 5'd9, 1'b0));

        // starve history built before reset must not survive it
        mreq = 1'b1; maddr = 6'd3;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("starve_restart%0d", k), k < 4 ? grant_m(6'd3, 5'd0, 1'b0) : grant_s(6'd3, 5'd9, 1'b0));
        end

`ifdef SC_REGARB_LOCK_EN
        rst = 1'b1;
        @(negedge clk);
        lock = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("lock_mir%0d", k), grant_m(6'd3, 5'd0, 1'b0));
        end
        lock = 1'b0;
        @(negedge clk);
        chk("lock_release_sp", grant_s(6'd3, 5'd9, 1'b0));
`endif

        mreq = 1'b0; sreq = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sc_regread_arbiter.md
Name: sc_regread_arbiter

Overview:
- Shares the 16-entry general-register read mux between two requesters: the microinstruction register (MIR field, 6-bit address) and the scratchpad/loader port (5-bit address).
- Registers the mux select line and both address buses; issues one-cycle grants and a data-valid strobe.
- Applies fixed MIR priority with a bounded-starvation guarantee for the scratchpad.
- Sits between the microsequencer/loader and the register read mux in the datapath.

Parameters:
DATAWIDTH_SCRATCHPAD_DIRECTION, 5, scratchpad address width
DATAWIDTH_MIR_DIRECTION, 6, MIR address field width
STARVE_LIMIT, 4, max consecutive MIR grants while scratchpad is pending (range 1..15)

Ports:
SC_REGARB_CLOCK_50  in  1  system clock, rising edge
SC_REGARB_RESET_InHigh  in  1  asynchronous reset, active-high
SC_REGARB_MIRReq_In  in  1  MIR read request, level, held until granted
SC_REGARB_MIRAddr_InBus  in  6  MIR register address
SC_REGARB_SPReq_In  in  1  scratchpad read request, level, held until granted
SC_REGARB_SPAddr_InBus  in  5  scratchpad register address
SC_REGARB_MIRGrant_Out  out  1  one-cycle MIR grant pulse
SC_REGARB_SPGrant_Out  out  1  one-cycle scratchpad grant pulse
SC_REGARB_MuxSelect_Out  out  1  mux select: 0 = scratchpad address, 1 = MIR address
SC_REGARB_MuxMIRSel_OutBus  out  6  registered MIR address to mux
SC_REGARB_MuxSPSel_OutBus  out  5  registered scratchpad address to mux
SC_REGARB_DataValid_Out  out  1  mux output valid for the granted requester this cycle
SC_REGARB_AddrErr_Out  out  1  granted address is at or above 16; mux returns register 0

Behaviour:
- One clock; reset is asynchronous and active-high. Every output is 0 during reset: both grants, select, both address buses, valid, error. State is IDLE and the starve counter is 0.
- FSM states:
  - IDLE: no grant this cycle.
  - GNT_MIR: MIR owns the mux this cycle.
  - GNT_SP: scratchpad owns the mux this cycle.
- Next state is evaluated every edge from the current request inputs, independent of the current state.
  - No request: IDLE.
  - MIR request only: GNT_MIR.
  - SP request only: GNT_SP.
  - Both: GNT_MIR, unless starve_cnt == STARVE_LIMIT, in which case GNT_SP.
- Latency: a request sampled at edge N produces grant, select, address and valid during cycle N+1. Grants can issue back-to-back every cycle.
- Entering GNT_MIR:
  - MIRGrant = 1, MuxSelect = 1, MuxMIRSel = MIRAddr, DataValid = 1.
  - MuxSPSel holds its previous value.
- Entering GNT_SP:
  - SPGrant = 1, MuxSelect = 0, MuxSPSel = SPAddr, DataValid = 1.
  - MuxMIRSel holds its previous value.
- Entering IDLE: grants, DataValid and AddrErr are 0. MuxSelect and both address buses hold their last values.
- Starve counter (4-bit):
  - Increments on each MIR grant issued while SPReq is high.
  - Clears on an SP grant, or on any edge where SPReq is low.
  - Saturates at STARVE_LIMIT.
- Requester rule: a requester that keeps its request high after its grant pulse is making a new request. Each grant corresponds to exactly one read.
- AddrErr:
  - Set with a grant when the granted address is 16 or above (MIR bits [5:4] ≠ 0, SP bit [4] = 1).
  - The grant and DataValid are still issued.
  - The address is forwarded unchanged; the mux defaults to register 0.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). Requests still high are re-arbitrated at the first edge after reset release. The starve history is lost.

Optional Feature:
- Macro: SC_REGARB_LOCK_EN.
- When defined:
  - Adds input SC_REGARB_MIRLock_In (1 bit).
  - A MIR grant issued while MIRLock_In is high sets a lock flag. The flag clears on the first edge where MIRLock_In is low.
  - While the flag is set, the starvation override is suppressed: MIR keeps priority for multi-cycle microcode sequences. The starve counter still saturates.
  - Reset clears the flag.
- When undefined: the port and flag are absent and arbitration is exactly as described in Behaviour.

Test Plan:
- Reset release with MIRReq = 1, MIRAddr = 6'd5 → at first edge, MIRGrant = 1, MuxSelect = 1, MuxMIRSel = 5, DataValid = 1, AddrErr = 0.
- SPReq = 1, SPAddr = 5'd12 alone for 3 cycles → SPGrant high 3 consecutive cycles, MuxSelect = 0, MuxSPSel = 12.
- Both requests held high continuously, STARVE_LIMIT = 4 → grant pattern M, M, M, M, S, M, M, M, M, S, ...; SP never waits more than 4 grants.
- MIRAddr = 6'd20 granted → AddrErr = 1 and DataValid = 1 for that cycle; MuxMIRSel = 20.
- Assert reset during GNT_SP → all outputs 0 without waiting for a clock edge. After release with SPReq still high, SPGrant at the first edge and starve counter restarted at 0.
- With SC_REGARB_LOCK_EN: both requests high, MIRLock_In high for 8 cycles → 8 consecutive MIR grants. Lock low → SP granted on the next edge (counter saturated at 4).
